hold_swap_controller: RTL and testbench

// Sequences the hold mechanic for the player playfield. It owns the held-tetromino register

---
 rtl/hold_swap_controller.sv | 113 +++++++++++
 tb/tb_hold_swap_controller.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/hold_swap_controller.sv
`default_nettype none
// ============================================================================
// Module      : hold_swap_controller (with hold_swap_pkg)
// Description : Hold-piece register and hold/lock arbitration. Swaps the
//               falling piece into the hold slot and requests a new spawn.
// Revision    : 1.0 - initial release
// ============================================================================

package hold_swap_pkg;
    typedef enum logic [2:0] {
        BLANK = 3'd0,
        I     = 3'd1,
        O     = 3'd2,
        T     = 3'd3,
        S     = 3'd4,
        Z     = 3'd5,
        J     = 3'd6,
        L     = 3'd7
    } tile_type_t;
endpackage

module hold_swap_controller
    import hold_swap_pkg::*;
#(
    parameter bit LOCKOUT_EN  = 1'b1,
    parameter int ACK_TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       game_start,
    input  logic       game_active,
    input  logic       hold_req,
    input  tile_type_t falling_type,
    input  logic       piece_locked,
    input  logic       spawn_ack,
    output tile_type_t hold_piece_type,
    output logic       hold_available,
    output logic       spawn_req,
    output logic       spawn_from_queue,
    output tile_type_t spawn_type,
    output logic       timeout_err
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_t;

    localparam int                 c_cnt_w   = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(ACK_TIMEOUT - 1);

    state_t             r_state;
    logic               r_hold_used;
    logic [c_cnt_w-1:0] r_count;
    logic               w_accept;

    assign hold_available = (r_state == ST_IDLE) && game_active
                            && (!r_hold_used || !LOCKOUT_EN);

    // A lock in the same cycle as a hold request takes precedence.
    assign w_accept = hold_req && hold_available
                      && (falling_type != BLANK) && !piece_locked;

    always_ff @(posedge clk) begin
        if (rst || game_start) begin
            r_state          <= ST_IDLE;
            hold_piece_type  <= BLANK;
            r_hold_used      <= 1'b0;
            spawn_req        <= 1'b0;
            spawn_from_queue <= 1'b0;
            spawn_type       <= BLANK;
            timeout_err      <= 1'b0;
            r_count          <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        hold_piece_type <= falling_type;
                        r_hold_used     <= 1'b1;
                        r_state         <= ST_REQ;
                        spawn_req       <= 1'b1;
                        // Empty hold slot means the replacement comes from the queue.
                        if (hold_piece_type == BLANK) begin
                            spawn_from_queue <= 1'b1;
                            spawn_type       <= BLANK;
                        end else begin
                            spawn_from_queue <= 1'b0;
                            spawn_type       <= hold_piece_type;
                        end
                    end
                end
                ST_REQ: begin
                    if (spawn_ack) begin
                        spawn_req <= 1'b0;
                        r_state   <= ST_IDLE;
                        r_count   <= '0;
                    end else if (r_count == c_cnt_max) begin
                        timeout_err <= 1'b1;
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            if (piece_locked) begin
                r_hold_used <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hold_swap_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_hold_swap_controller
// Description : Directed plus random bench for hold_swap_controller, two
//               instances (lockout on / off) against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hold_swap_controller;
    import hold_swap_pkg::*;

    localparam int TO = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, game_start, game_active, hold_req, piece_locked, spawn_ack;
    tile_type_t falling_type;

    tile_type_t hold0, hold1, stype0, stype1;
    logic       avail0, avail1, sreq0, sreq1, sfq0, sfq1, terr0, terr1;

    hold_swap_controller #(.LOCKOUT_EN(1'b1), .ACK_TIMEOUT(TO)) u_dut0 (
        .clk(clk), .rst(rst), .game_start(game_start), .game_active(game_active),
        .hold_req(hold_req), .falling_type(falling_type), .piece_locked(piece_locked),
        .spawn_ack(spawn_ack), .hold_piece_type(hold0), .hold_available(avail0),
        .spawn_req(sreq0), .spawn_from_queue(sfq0), .spawn_type(stype0),
        .timeout_err(terr0)
    );

    hold_swap_controller #(.LOCKOUT_EN(1'b0), .ACK_TIMEOUT(TO)) u_dut1 (
        .clk(clk), .rst(rst), .game_start(game_start), .game_active(game_active),
        .hold_req(hold_req), .falling_type(falling_type), .piece_locked(piece_locked),
        .spawn_ack(spawn_ack), .hold_piece_type(hold1), .hold_available(avail1),
        .spawn_req(sreq1), .spawn_from_queue(sfq1), .spawn_type(stype1),
        .timeout_err(terr1)
    );

    // Reference model: one entry per instance (0 = lockout, 1 = unlimited).
    tile_type_t m_hold  [2];
    tile_type_t m_stype [2];
    bit         m_used  [2];
    bit         m_busy  [2];
    bit         m_fq    [2];
    bit         m_err   [2];
    int         m_wait  [2];
    bit         m_lock  [2] = '{1'b1, 1'b0};

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input int k, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s dut%0d observed=%0d expected=%0d", tag, k, obs, exp);
        end
    endtask

    function automatic bit model_avail(input int k);
        return !m_busy[k] && game_active && (!m_used[k] || !m_lock[k]);
    endfunction

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            if (rst || game_start) begin
                m_hold[k] = BLANK; m_stype[k] = BLANK; m_used[k] = 0;
                m_busy[k] = 0; m_fq[k] = 0; m_err[k] = 0; m_wait[k] = 0;
            end else begin
                if (m_busy[k]) begin
                    if (spawn_ack) begin
                        m_busy[k] = 0;
                        m_wait[k] = 0;
                    end else begin
                        m_wait[k]++;
                        if (m_wait[k] >= TO) m_err[k] = 1;
                    end
                end else if (hold_req && model_avail(k) && falling_type != BLANK
                             && !piece_locked) begin
                    m_busy[k]  = 1;
                    m_fq[k]    = (m_hold[k] == BLANK);
                    m_stype[k] = m_hold[k];
                    m_hold[k]  = falling_type;
                    m_used[k]  = 1;
                end
                if (piece_locked) m_used[k] = 0;
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".hold"},  0, 32'(hold0),  32'(m_hold[0]));
        chk({tag, ".avail"}, 0, 32'(avail0), 32'(model_avail(0)));
        chk({tag, ".sreq"},  0, 32'(sreq0),  32'(m_busy[0]));
        chk({tag, ".terr"},  0, 32'(terr0),  32'(m_err[0]));
        chk({tag, ".hold"},  1, 32'(hold1),  32'(m_hold[1]));
        chk({tag, ".avail"}, 1, 32'(avail1), 32'(model_avail(1)));
        chk({tag, ".sreq"},  1, 32'(sreq1),  32'(m_busy[1]));
        chk({tag, ".terr"},  1, 32'(terr1),  32'(m_err[1]));
        // Spawn source is only meaningful once a hold has been accepted.
        if (m_busy[0]) begin
            chk({tag, ".sfq"},   0, 32'(sfq0),   32'(m_fq[0]));
            chk({tag, ".stype"}, 0, 32'(stype0), 32'(m_stype[0]));
        end
        if (m_busy[1]) begin
            chk({tag, ".sfq"},   1, 32'(sfq1),   32'(m_fq[1]));
            chk({tag, ".stype"}, 1, 32'(stype1), 32'(m_stype[1]));
        end
    endtask

    task automatic step(input string tag, input bit hr = 0, input bit pl = 0,
                        input bit ack = 0, input bit gs = 0, input bit r = 0);
        hold_req = hr; piece_locked = pl; spawn_ack = ack; game_start = gs; rst = r;
        @(posedge clk);
        model_step();
        #1;
        check_all(tag);
        hold_req = 0; piece_locked = 0; spawn_ack = 0; game_start = 0; rst = 0;
    endtask

    initial begin
        rst = 1; game_start = 0; game_active = 0; hold_req = 0;
        piece_locked = 0; spawn_ack = 0; falling_type = BLANK;
        step("reset", .r(1));
        chk("reset.hold", 0, 32'(hold0), 32'(BLANK));
        chk("reset.sreq", 0, 32'(sreq0), 32'd0);
        chk("reset.sfq",  0, 32'(sfq0),  32'd0);

        // First hold from empty slot pulls from the queue.
        game_active = 1; falling_type = T;
        step("hold_first", .hr(1));
        chk("first.hold", 0, 32'(hold0), 32'(T));
        chk("first.sfq",  0, 32'(sfq0),  32'd1);
        step("wait1");
        step("wait2");
        step("ack1", .ack(1));
        chk("ack1.sreq", 0, 32'(sreq0), 32'd0);
        step("gap");

        // Swap with existing hold after a lock.
        step("lock1", .pl(1));
        falling_type = I;
        step("hold_swap", .hr(1));
        chk("swap.hold",  0, 32'(hold0),  32'(I));
        chk("swap.stype", 0, 32'(stype0), 32'(T));
        chk("swap.sfq",   0, 32'(sfq0),   32'd0);
        step("ack2", .ack(1));
        chk("lockout.avail0", 0, 32'(avail0), 32'd0);
        chk("lockout.avail1", 1, 32'(avail1), 32'd1);

        // Lockout: dut0 ignores, dut1 accepts.
        falling_type = O;
        step("hold_locked_out", .hr(1));
        step("ack3", .ack(1));
        step("lock2", .pl(1));
        falling_type = S;
        step("hold_after_lock", .hr(1));
        step("ack4", .ack(1));
        step("gap2");

        // Same-cycle hold and lock: lock wins.
        falling_type = Z;
        step("hold_and_lock", .hr(1), .pl(1));
        chk("holdlock.sreq", 0, 32'(sreq0), 32'd0);

        // Blank falling piece and inactive game are both rejected.
        falling_type = BLANK;
        step("hold_blank", .hr(1));
        game_active = 0; falling_type = J;
        step("hold_inactive", .hr(1));
        game_active = 1;

        // Timeout with late ack; error sticks until game_start.
        step("hold_to", .hr(1));
        for (int c = 0; c < TO + 2; c++) step("to_wait");
        chk("to.terr", 0, 32'(terr0), 32'd1);
        chk("to.sreq", 0, 32'(sreq0), 32'd1);
        step("to_ack", .ack(1));
        step("to_idle");
        step("game_start", .gs(1));

        // Reset mid-request, and game_active dropping mid-request.
        falling_type = L;
        step("hold_rst", .hr(1));
        step("rst_mid", .r(1));
        chk("rstmid.hold", 0, 32'(hold0), 32'(BLANK));
        step("hold_ga", .hr(1));
        game_active = 0;
        step("ga_low");
        step("ga_ack", .ack(1));
        game_active = 1;

        for (int n = 0; n < 600; n++) begin
            game_active  = ($urandom_range(0, 7) != 0);
            falling_type = tile_type_t'($urandom_range(0, 7));
            step("rand",
                 .hr($urandom_range(0, 2) == 0),
                 .pl($urandom_range(0, 7) == 0),
                 .ack($urandom_range(0, 3) == 0),
                 .gs($urandom_range(0, 79) == 0),
                 .r($urandom_range(0, 79) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
